// File: rtl/product_bcd_pkg.sv
// Shared widths, FSM states and double-dabble constants for the product BCD converter.
package product_bcd_pkg;

  localparam int unsigned IN_W   = 512;
  localparam int unsigned DIGITS = 155;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(IN_W + 1);
  localparam int unsigned NDIG_W = 8;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import product_bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i + BCD_ADJ_ADD) : digit_i;

endmodule

// File: rtl/product_bcd_converter.sv
// Serial double-dabble converter: 512-bit product in, 155 packed BCD digits out.
// Optional significant-digit count output enabled by PRODUCT_BCD_NDIG_EN.
module product_bcd_converter
  import product_bcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BCD_W-1:0]  bcd
`ifdef PRODUCT_BCD_NDIG_EN
  ,
  output logic [NDIG_W-1:0] out_ndigits
`endif
);

  state_e             state_q, state_d;
  logic [IN_W-1:0]    shreg_q, shreg_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift_c;
  logic               last_shift_c;
  logic               unused_top_bit;

  // Per-digit add-3 correction on the current register value.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  // The top digit never reaches 8 before a shift, so its corrected MSB is always zero.
  assign unused_top_bit = bcd_adj[BCD_W-1];
  assign bcd_shift_c    = {bcd_adj[BCD_W-2:0], shreg_q[IN_W-1]};
  assign last_shift_c   = (cnt_q == CNT_W'(IN_W - 1));

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = SHIFT;
          shreg_d    = in_data;
          bcd_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
        end
      end
      SHIFT: begin
        bcd_d   = bcd_shift_c;
        shreg_d = {shreg_q[IN_W-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_shift_c) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;

`ifdef PRODUCT_BCD_NDIG_EN
  logic [NDIG_W-1:0] ndig_c;
  logic [NDIG_W-1:0] ndig_q;

  // Priority encoder on the final shifted value; highest nonzero digit wins, zero reports 1.
  always_comb begin
    ndig_c = NDIG_W'(1);
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (bcd_shift_c[4*i +: 4] != 4'd0) ndig_c = NDIG_W'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ndig_q <= '0;
    end else if ((state_q == SHIFT) && last_shift_c) begin
      ndig_q <= ndig_c;
    end
  end

  assign out_ndigits = ndig_q;
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed self-checking bench for product_bcd_converter (also covers PRODUCT_BCD_NDIG_EN).
module tb_product_bcd_converter;
  import product_bcd_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BCD_W-1:0] bcd;
`ifdef PRODUCT_BCD_NDIG_EN
  logic [NDIG_W-1:0] out_ndigits;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_bcd_converter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd)
`ifdef PRODUCT_BCD_NDIG_EN
    ,
    .out_ndigits (out_ndigits)
`endif
  );

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one input, then scramble in_data to prove it is sampled only on the accept edge.
  task automatic start(input logic [IN_W-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 640'(out_valid), 640'(1'b0));
    chk({tag, "_ready_back"}, 640'(in_ready), 640'(1'b1));
  endtask

  int n;
  int acc_cyc [2];
  int nacc;
  int nout;
  logic acc_now;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 640'(in_ready), 640'(1'b1));
    chk("rst_out_valid", 640'(out_valid), 640'(1'b0));
    chk("rst_bcd", 640'(bcd), 640'(0));
`ifdef PRODUCT_BCD_NDIG_EN
    chk("rst_ndig", 640'(out_ndigits), 640'(0));
`endif

    // Zero input: exact latency and all-zero result.
    start('0);
    chk("zero_in_ready_low", 640'(in_ready), 640'(1'b0));
    wait_out(n);
    chk("zero_latency", 640'(n), 640'(512));
    chk("zero_bcd", 640'(bcd), 640'(0));
`ifdef PRODUCT_BCD_NDIG_EN
    chk("zero_ndig", 640'(out_ndigits), 640'(1));
`endif
    finish_out("zero");

    // 12345.
    start(IN_W'(12345));
    wait_out(n);
    chk("d12345_latency", 640'(n), 640'(512));
    chk("d12345_low", 640'(bcd[19:0]), 640'(20'h12345));
    chk("d12345_high", 640'(bcd[BCD_W-1:20]), 640'(0));
`ifdef PRODUCT_BCD_NDIG_EN
    chk("d12345_ndig", 640'(out_ndigits), 640'(5));
`endif
    finish_out("d12345");

    // 2^512-1, then 20 cycles of back-pressure with a competing in_valid.
    start('1);
    wait_out(n);
    chk("max_latency", 640'(n), 640'(512));
    chk("max_top", 640'(bcd[BCD_W-1:BCD_W-40]), 640'(40'h1340780792));
    chk("max_bottom", 640'(bcd[23:0]), 640'(24'h084095));
`ifdef PRODUCT_BCD_NDIG_EN
    chk("max_ndig", 640'(out_ndigits), 640'(155));
`endif
    in_data  = IN_W'(777);
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("bp_valid", 640'(out_valid), 640'(1'b1));
      chk("bp_ready", 640'(in_ready), 640'(1'b0));
      chk("bp_top", 640'(bcd[BCD_W-1:BCD_W-40]), 640'(40'h1340780792));
      chk("bp_bottom", 640'(bcd[23:0]), 640'(24'h084095));
    end
    in_valid = 1'b0;
    finish_out("bp");
    tick();
    chk("bp_not_accepted", 640'(in_ready), 640'(1'b1));

    // Reset at shift cycle 200 of 999.
    start(IN_W'(999));
    repeat (200) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 640'(out_valid), 640'(1'b0));
    chk("mid_rst_bcd", 640'(bcd), 640'(0));
    chk("mid_rst_ready", 640'(in_ready), 640'(1'b1));
    wait_out(n);
    chk("mid_rst_no_pulse", 640'(n), 640'(600));
    start(IN_W'(999));
    wait_out(n);
    chk("d999_latency", 640'(n), 640'(512));
    chk("d999_low", 640'(bcd[11:0]), 640'(12'h999));
    chk("d999_high", 640'(bcd[BCD_W-1:12]), 640'(0));
`ifdef PRODUCT_BCD_NDIG_EN
    chk("d999_ndig", 640'(out_ndigits), 640'(3));
`endif
    finish_out("d999");

    // Back-to-back 1 then 10 with in_valid and out_ready held high.
    in_valid  = 1'b1;
    in_data   = IN_W'(1);
    out_ready = 1'b1;
    nacc = 0;
    nout = 0;
    for (int c = 0; c < 1200 && nout < 2; c++) begin
      acc_now = in_ready;
      if (out_valid === 1'b1) begin
        if (nout == 0) begin
          chk("b2b_out1", 640'(bcd), 640'(4'h1));
`ifdef PRODUCT_BCD_NDIG_EN
          chk("b2b_ndig1", 640'(out_ndigits), 640'(1));
`endif
        end else begin
          chk("b2b_out2", 640'(bcd), 640'(8'h10));
`ifdef PRODUCT_BCD_NDIG_EN
          chk("b2b_ndig2", 640'(out_ndigits), 640'(2));
`endif
        end
        nout++;
      end
      tick();
      if (acc_now === 1'b1 && nacc < 2) begin
        acc_cyc[nacc] = c;
        nacc++;
        in_data = IN_W'(10);
        if (nacc == 2) in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    chk("b2b_naccepts", 640'(nacc), 640'(2));
    chk("b2b_nouts", 640'(nout), 640'(2));
    chk("b2b_spacing", 640'(acc_cyc[1] - acc_cyc[0]), 640'(IN_W + 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/product_bcd_converter.md
# product_bcd_converter

Sequential binary-to-BCD converter directly downstream of the 256×256 decimal-split Karatsuba multiplier. It accepts one 512-bit unsigned product over a valid/ready handshake and converts it with serial double-dabble, one bit per cycle. It then presents all 155 packed BCD digits to the display/readout stage on a second valid/ready handshake.

## Interface
- IN_W, 512: binary input width. Conversion takes IN_W shift cycles.
- DIGITS, 155: BCD digit count, ceil(IN_W·log10 2). 2^512−1 has exactly 155 digits.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  IN_W  unsigned product from the multiplier's `result`.
- out_valid  output  1  bcd holds a finished conversion.
- out_ready  input  1  consumer accepts bcd.
- bcd  output  4·DIGITS  packed BCD. Digit 0 (units) is in bits [3:0]; digit i is in [4i+3:4i].
- out_ndigits  output  8  significant digit count. Present only with PRODUCT_BCD_NDIG_EN.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid: load in_data into a shift register, clear the BCD register, clear the bit counter, go to SHIFT.
  - SHIFT: once per cycle, add 3 to every BCD digit that is ≥5, then shift {bcd, shreg} left by one. The MSB of shreg enters bit 0 of digit 0. Increment the counter. After the IN_W-th shift, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Digit correction is combinational on the current register value and applied before the shift. The shift itself is a single registered update.
- Every digit stays in 0–9 at all times. The top digit never overflows, because DIGITS is sized for the full input range.
- Counter width: clog2(IN_W+1). Terminal compare: count == IN_W−1 on the last shift.
- in_valid while not in IDLE is ignored; the upstream must hold in_valid and in_data until in_ready.
- in_data is sampled only on the accept edge. Later changes have no effect.
- bcd is stable from the rise of out_valid until the output handshake completes. Any out_ready seen outside DONE is ignored.
- Reset values: state=IDLE, in_ready=1 after reset, out_valid=0, bcd=0, counter=0, shreg=0, out_ndigits=0.
- Reset mid-SHIFT or mid-DONE aborts the conversion. The partial result is discarded, with no out_valid pulse, and the outputs return to reset values on the next edge.

## Timing
- Accept edge T: in_valid & in_ready sampled high. in_ready drops after T.
- Shift edges: T+1 … T+IN_W.
- out_valid rises after edge T+IN_W, giving a latency of IN_W cycles from accept to out_valid.
- If out_ready is already high, the output handshake completes at edge T+IN_W+1. in_ready is high after that edge, and the next accept can occur at T+IN_W+2.
- Peak throughput: one conversion per IN_W+2 cycles.
- Back-pressure: out_valid and bcd hold indefinitely while out_ready=0.

## Configuration
- PRODUCT_BCD_NDIG_EN defined:
  - Adds the out_ndigits port.
  - out_ndigits = index of the most significant nonzero digit + 1, with value 0 reporting 1.
  - It is registered on the transition into DONE, valid with out_valid, and held with bcd.
  - A priority encoder is added over the DIGITS digit-nonzero flags.
- Not defined: the port, the encoder and the register are absent. All other behaviour is identical.

## Structure
- Shared package product_bcd_pkg holds:
  - IN_W and DIGITS localparams;
  - the state enum {IDLE, SHIFT, DONE};
  - the constants BCD_ADJ_THRESH=4'd5 and BCD_ADJ_ADD=4'd3.
- Sub-module bcd_digit_adj: 4-bit combinational add-3-if-≥5 cell, instantiated DIGITS times in a generate loop.
- Top level: FSM, counter, shift registers, optional digit-count encoder.

## Test plan
- in_data=0 → after exactly 512 cycles, bcd=0 and out_valid=1. With the macro, out_ndigits=1.
- in_data=12345 → bcd[19:0]=20'h12345, all higher digits 0. With the macro, out_ndigits=5.
- in_data=2^512−1 → digit 154..145 = 1,3,4,0,7,8,0,7,9,2 and digit 5..0 = 0,8,4,0,9,5. With the macro, out_ndigits=155.
- out_ready held low for 20 cycles after out_valid → bcd and out_valid stable throughout, in_ready=0, and a new in_valid is not accepted. Then out_ready=1 for one cycle → out_valid=0 and in_ready=1 next cycle.
- rst pulsed at shift cycle 200 of a conversion of 999 → next edge gives IDLE, out_valid=0, bcd=0. A fresh conversion of 999 then yields bcd[11:0]=12'h999.
- Back-to-back inputs 1 then 10 with in_valid held → second accept occurs exactly IN_W+2 cycles after the first. The outputs are 4'h1, then 8'h10.
